softmax_row_loader: RTL and testbench

SOFTMAX_ROW_LOADER -- requirements
Module: softmax_row_loader

---
 rtl/softmax_row_loader_if.sv | 25 ++
 rtl/softmax_row_loader.sv | 86 ++++++++
 tb/tb_softmax_row_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/softmax_row_loader_if.sv
`default_nettype none
// softmax_row_loader_if: element stream in, assembled row out. Rev 1.0
interface softmax_row_loader_if #(
  parameter int N = 64
);
  logic            s_valid;
  logic            s_ready;
  logic [15:0]     s_data;
  logic            s_last;
  logic            x_out_valid;
  logic            x_out_ready;
  logic [N*16-1:0] x_out;
  logic [6:0]      row_len;

  modport slave (
    input  s_valid, s_data, s_last, x_out_ready,
    output s_ready, x_out_valid, x_out, row_len
  );

  modport master (
    output s_valid, s_data, s_last, x_out_ready,
    input  s_ready, x_out_valid, x_out, row_len
  );
endinterface
`default_nettype wire

// File: rtl/softmax_row_loader.sv
`default_nettype none
// softmax_row_loader: packs an FP16 element stream into PAD-filled N-lane rows,
// ping-pong buffered so one finished row can wait while the next fills. Rev 1.0
module softmax_row_loader #(
  parameter int          N   = 64,
  parameter logic [15:0] PAD = 16'hFC00
) (
  input  logic                 clk,
  input  logic                 rst,
  softmax_row_loader_if.slave  bus
);
  localparam int CW = $clog2(N + 1);

  logic [1:0]      full;
  logic            wr_sel;
  logic            rd_sel;
  logic [CW-1:0]   cnt;
  logic [6:0]      len0;
  logic [6:0]      len1;
  logic [N*16-1:0] row0;
  logic [N*16-1:0] row1;
  logic [N*16-1:0] row_view;

  logic take_elem;
  logic take_row;
  logic close_row;

  // Only registered occupancy (and reset) reach s_ready; x_out_ready never does.
  assign bus.s_ready     = !rst && !(full[0] && full[1]);
  assign bus.x_out_valid = full[rd_sel];
  assign bus.row_len     = full[rd_sel] ? (rd_sel ? len1 : len0) : 7'd0;
  assign bus.x_out       = row_view;

  assign take_elem = bus.s_valid && bus.s_ready;
  assign take_row  = bus.x_out_valid && bus.x_out_ready;
  assign close_row = take_elem && (bus.s_last || (cnt == CW'(N - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full   <= 2'b00;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      cnt    <= '0;
      len0   <= 7'd0;
      len1   <= 7'd0;
    end else begin
      // A buffer being consumed is never the one being filled, so these
      // two updates always touch different bits of full.
      if (take_row) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
      end
      if (close_row) begin
        full[wr_sel] <= 1'b1;
        wr_sel       <= ~wr_sel;
        cnt          <= '0;
        if (wr_sel) len1 <= 7'(cnt) + 7'd1;
        else        len0 <= 7'(cnt) + 7'd1;
      end else if (take_elem) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Lane storage needs no reset: lanes at or beyond row_len are masked to PAD.
  always_ff @(posedge clk) begin
    if (take_elem) begin
      if (wr_sel) row1[{cnt, 4'b0000} +: 16] <= bus.s_data;
      else        row0[{cnt, 4'b0000} +: 16] <= bus.s_data;
    end
  end

  always_comb begin
    row_view = '0;
    for (int i = 0; i < N; i++) begin
      if (!full[rd_sel]) begin
        row_view[i*16 +: 16] = 16'h0000;
      end else if (rd_sel) begin
        row_view[i*16 +: 16] = (7'(i) < len1) ? row1[i*16 +: 16] : PAD;
      end else begin
        row_view[i*16 +: 16] = (7'(i) < len0) ? row0[i*16 +: 16] : PAD;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_softmax_row_loader.sv
`default_nettype none
// tb_softmax_row_loader: directed stimulus with a row scoreboard for softmax_row_loader.
module tb_softmax_row_loader;
  localparam int          N   = 64;
  localparam logic [15:0] PAD = 16'hFC00;

  typedef struct {
    logic [N*16-1:0] data;
    logic [6:0]      len;
  } row_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  softmax_row_loader_if #(.N(N)) bus ();

  softmax_row_loader #(.N(N), .PAD(PAD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int rows_out = 0;
  int stalls = 0;
  row_t sb[$];
  int pop_cycle[$];

  logic [N*16-1:0] cur;
  int k;

  task automatic chk(input string tag, input logic [N*16-1:0] obs, input logic [N*16-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    cur = {N{PAD}};
    k = 0;
  endtask

  // Scores one clock: decides which transfers happen at the coming edge from
  // values settled since the previous edge, then advances to #1 after it.
  task automatic tick();
    logic ae, ar;
    row_t r;
    ae = bus.s_valid && bus.s_ready;
    ar = bus.x_out_valid && bus.x_out_ready;
    if (ar) begin
      if (sb.size() == 0) begin
        chk("row_unexpected", 0, 1);
      end else begin
        r = sb.pop_front();
        chk("row_data", bus.x_out, r.data);
        chk("row_len", bus.row_len, r.len);
      end
      rows_out++;
      pop_cycle.push_back(cycle);
    end
    if (ae) begin
      cur[k*16 +: 16] = bus.s_data;
      k++;
      if (bus.s_last || k == N) begin
        r.data = cur;
        r.len  = 7'(k);
        sb.push_back(r);
        model_clear();
      end
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    bit got;
    got = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    for (int t = 0; t < 300 && !got; t++) begin
      if (bus.s_ready) got = 1'b1;
      else stalls++;
      tick();
    end
    bus.s_valid = 1'b0;
    bus.s_data  = 16'($urandom);
    bus.s_last  = 1'b0;
    if (!got) chk("send_timeout", {1023'd0, got}, 1);
  endtask

  task automatic drain();
    bus.x_out_ready = 1'b1;
    for (int t = 0; t < 300 && sb.size() > 0; t++) tick();
    chk("drain_empty", sb.size(), 0);
    tick();
    chk("drain_idle_valid", bus.x_out_valid, 1'b0);
    bus.x_out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_s_ready", bus.s_ready, 1'b0);
    chk("rst_valid", bus.x_out_valid, 1'b0);
    chk("rst_x_out", bus.x_out, '0);
    chk("rst_row_len", bus.row_len, 7'd0);
    sb.delete();
    model_clear();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", bus.s_ready, 1'b1);
  endtask

  initial begin
    int r0;
    bus.s_valid     = 1'b0;
    bus.s_data      = 16'h0000;
    bus.s_last      = 1'b0;
    bus.x_out_ready = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Full row, lane k = k, explicit last on the N-th element.
    for (int i = 0; i < N - 1; i++) send(16'(i), 1'b0);
    chk("t1_valid_before_last", bus.x_out_valid, 1'b0);
    send(16'(N - 1), 1'b1);
    chk("t1_valid_latency", bus.x_out_valid, 1'b1);
    chk("t1_row_len", bus.row_len, 7'd64);
    chk("t1_lane5", bus.x_out[5*16 +: 16], 16'd5);
    drain();

    // Short row padded with -inf.
    send(16'h3C00, 1'b0);
    send(16'h4000, 1'b0);
    send(16'h4200, 1'b1);
    chk("t2_row_len", bus.row_len, 7'd3);
    chk("t2_lane2", bus.x_out[2*16 +: 16], 16'h4200);
    chk("t2_lane3_pad", bus.x_out[3*16 +: 16], 16'hFC00);
    chk("t2_lane63_pad", bus.x_out[63*16 +: 16], 16'hFC00);
    drain();

    // Back-pressure: two full rows fill both buffers.
    for (int i = 0; i < 2 * N; i++) send(16'($urandom), (i == 2 * N - 1) ? 1'b1 : 1'b0);
    chk("t3_s_ready_low", bus.s_ready, 1'b0);
    chk("t3_valid", bus.x_out_valid, 1'b1);
    chk("t3_row0", bus.x_out, sb[0].data);
    bus.s_valid = 1'b1;
    bus.s_data  = 16'hABCD;
    for (int i = 0; i < 3; i++) tick();
    chk("t3_row0_held", bus.x_out, sb[0].data);
    chk("t3_len_held", bus.row_len, 7'd64);
    bus.x_out_ready = 1'b1;
    chk("t3_s_ready_ready_cycle", bus.s_ready, 1'b0);
    tick();
    bus.x_out_ready = 1'b0;
    bus.s_valid = 1'b0;
    chk("t3_row1_valid", bus.x_out_valid, 1'b1);
    chk("t3_row1", bus.x_out, sb[0].data);
    chk("t3_s_ready_back", bus.s_ready, 1'b1);
    drain();

    // N elements without last, then one with last: two rows of 64 and 1.
    r0 = rows_out;
    for (int i = 0; i < N; i++) send(16'($urandom), 1'b0);
    send(16'h1234, 1'b1);
    drain();
    chk("t4_row_count", rows_out - r0, 2);

    // Reset in the middle of a row discards it.
    bus.x_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(16'h7000 + 16'(i), 1'b0);
    do_reset();
    bus.x_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_no_row", bus.x_out_valid, 1'b0);
    end
    for (int i = 0; i < N; i++) send(16'h5000 + 16'(i), 1'b0);
    drain();

    // Continuous stream with downstream always ready.
    stalls = 0;
    pop_cycle.delete();
    bus.x_out_ready = 1'b1;
    for (int i = 0; i < 3 * N; i++) send(16'($urandom), 1'b0);
    drain();
    chk("t6_stalls", stalls, 0);
    chk("t6_rows", pop_cycle.size(), 3);
    if (pop_cycle.size() == 3) begin
      chk("t6_gap1", pop_cycle[1] - pop_cycle[0], N);
      chk("t6_gap2", pop_cycle[2] - pop_cycle[1], N);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
